// File: rtl/capture_table.sv
// capture_table: capture-tree recorder downstream of the pattern-matching VM.
// Turns OPEN/CLOSE/RESTORE/CLEAR events into a flat table of
// {name, start, end, level, parent, matched} entries. It reports the current
// capture index back to the core, mirrors the root entry, and provides an
// independent registered read port.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   op_valid/op_ready/op_*        capture event handshake and payload
//   capidx, cap_len               current capture index, entries in use
//   notify_valid/notify_idx       one-cycle pulse carrying the closed index
//   root_matched, root_end        registered mirror of entry 0
//   err_overflow, err_underflow   sticky error flags (cleared by rst/CLEAR)
//   rd_en/rd_idx/rd_valid/rd_data random-access read, 1-cycle latency
//
// Optional feature macro: CAPTURE_TABLE_STATS_EN adds stat_hwm (high-water
// mark of cap_len) and stat_ops (saturating count of accepted events).
module capture_table #(
    parameter int DEPTH  = 64,
    parameter int POS_W  = 16,
    parameter int NAME_W = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 op_valid,
    output logic                                 op_ready,
    input  logic [1:0]                           op_kind,
    input  logic [NAME_W-1:0]                    op_name,
    input  logic [POS_W-1:0]                     op_pos,
    input  logic [IDX_W-1:0]                     op_capidx,
    output logic [IDX_W-1:0]                     capidx,
    output logic [IDX_W:0]                       cap_len,
    output logic                                 notify_valid,
    output logic [IDX_W-1:0]                     notify_idx,
    output logic                                 root_matched,
    output logic [POS_W-1:0]                     root_end,
    output logic                                 err_overflow,
    output logic                                 err_underflow,
`ifdef CAPTURE_TABLE_STATS_EN
    output logic [IDX_W:0]                       stat_hwm,
    output logic [31:0]                          stat_ops,
`endif
    input  logic                                 rd_en,
    input  logic [IDX_W-1:0]                     rd_idx,
    output logic                                 rd_valid,
    output logic [NAME_W+2*POS_W+8+IDX_W+1-1:0]  rd_data
);
    localparam int RD_W = NAME_W + 2*POS_W + 8 + IDX_W + 1;
    localparam logic [1:0] K_OPEN = 2'd0, K_CLOSE = 2'd1, K_RESTORE = 2'd2, K_CLEAR = 2'd3;
    localparam logic [0:0] S_IDLE = 1'b0, S_EXEC = 1'b1;
    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    // Table storage: one array per field so CLOSE touches only end/matched.
    logic [NAME_W-1:0] tbl_name_q    [DEPTH];
    logic [POS_W-1:0]  tbl_start_q   [DEPTH];
    logic [POS_W-1:0]  tbl_end_q     [DEPTH];
    logic [7:0]        tbl_level_q   [DEPTH];
    logic [IDX_W-1:0]  tbl_parent_q  [DEPTH];
    logic              tbl_matched_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  capidx_q, capidx_d;
    logic [IDX_W:0]    cap_len_q, cap_len_d;
    logic              err_ov_q, err_ov_d, err_un_q, err_un_d;
    logic              notify_valid_q, notify_valid_d;
    logic [IDX_W-1:0]  notify_idx_q, notify_idx_d;
    logic              root_matched_q, root_matched_d;
    logic [POS_W-1:0]  root_end_q, root_end_d;
    logic              rd_valid_q, rd_valid_d;
    logic [RD_W-1:0]   rd_data_q, rd_data_d;
    // Operands held across the EXEC cycle of a read-modify-write.
    logic              pend_close_q, pend_close_d;
    logic [NAME_W-1:0] pend_name_q, pend_name_d;
    logic [POS_W-1:0]  pend_pos_q, pend_pos_d;
    logic [7:0]        rmw_level_q, rmw_level_d;
    logic [IDX_W-1:0]  rmw_parent_q, rmw_parent_d;

    logic              accept, wr_open, wr_close;
    logic [IDX_W-1:0]  wr_idx, wr_parent;
    logic [NAME_W-1:0] wr_name;
    logic [POS_W-1:0]  wr_start, wr_end;
    logic [7:0]        wr_level;

    assign accept = op_valid && (state_q == S_IDLE);

    always_comb begin
        state_d        = state_q;
        capidx_d       = capidx_q;
        cap_len_d      = cap_len_q;
        err_ov_d       = err_ov_q;
        err_un_d       = err_un_q;
        notify_valid_d = 1'b0;
        notify_idx_d   = notify_idx_q;
        root_matched_d = root_matched_q;
        root_end_d     = root_end_q;
        pend_close_d   = pend_close_q;
        pend_name_d    = pend_name_q;
        pend_pos_d     = pend_pos_q;
        rmw_level_d    = rmw_level_q;
        rmw_parent_d   = rmw_parent_q;
        wr_open        = 1'b0;
        wr_close       = 1'b0;
        wr_idx         = '0;
        wr_name        = '0;
        wr_start       = '0;
        wr_end         = '0;
        wr_level       = '0;
        wr_parent      = '0;

        if (state_q == S_EXEC) begin
            state_d = S_IDLE;
            if (pend_close_q) begin
                wr_close       = 1'b1;
                wr_idx         = capidx_q;
                wr_end         = pend_pos_q;
                capidx_d       = rmw_parent_q;
                notify_valid_d = 1'b1;
                notify_idx_d   = capidx_q;
            end else begin
                wr_open   = 1'b1;
                wr_idx    = cap_len_q[IDX_W-1:0];
                wr_name   = pend_name_q;
                wr_start  = pend_pos_q;
                wr_level  = (rmw_level_q == 8'hFF) ? 8'hFF : rmw_level_q + 8'd1;
                wr_parent = capidx_q;
                capidx_d  = cap_len_q[IDX_W-1:0];
                cap_len_d = cap_len_q + (IDX_W+1)'(1);
            end
        end else if (accept) begin
            unique case (op_kind)
                K_OPEN: begin
                    if (cap_len_q == FULL) begin
                        err_ov_d = 1'b1;
                    end else if (cap_len_q == '0) begin
                        // Root capture: nothing to look up, write directly.
                        wr_open   = 1'b1;
                        wr_name   = op_name;
                        wr_start  = op_pos;
                        capidx_d  = '0;
                        cap_len_d = (IDX_W+1)'(1);
                    end else begin
                        pend_close_d = 1'b0;
                        pend_name_d  = op_name;
                        pend_pos_d   = op_pos;
                        rmw_level_d  = tbl_level_q[capidx_q];
                        state_d      = S_EXEC;
                    end
                end
                K_CLOSE: begin
                    if (cap_len_q == '0) begin
                        err_un_d = 1'b1;
                    end else begin
                        pend_close_d = 1'b1;
                        pend_pos_d   = op_pos;
                        rmw_parent_d = tbl_parent_q[capidx_q];
                        state_d      = S_EXEC;
                    end
                end
                K_RESTORE: begin
                    if ((cap_len_q != '0) && ({1'b0, op_capidx} >= cap_len_q))
                        err_un_d = 1'b1;
                    else
                        capidx_d = op_capidx;
                end
                default: begin
                    cap_len_d      = '0;
                    capidx_d       = '0;
                    err_ov_d       = 1'b0;
                    err_un_d       = 1'b0;
                    root_matched_d = 1'b0;
                end
            endcase
        end

        // Root mirror follows any write landing on entry 0 (OPEN writes end=0).
        if ((wr_open || wr_close) && (wr_idx == '0)) begin
            root_matched_d = wr_close;
            root_end_d     = wr_end;
        end

        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            if ({1'b0, rd_idx} < cap_len_q)
                rd_data_d = {tbl_matched_q[rd_idx], tbl_parent_q[rd_idx], tbl_level_q[rd_idx],
                             tbl_end_q[rd_idx], tbl_start_q[rd_idx], tbl_name_q[rd_idx]};
            else
                rd_data_d = '0;
        end
    end

    // Table writes are suppressed under reset so an EXEC in flight is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_open) begin
                tbl_name_q[wr_idx]    <= wr_name;
                tbl_start_q[wr_idx]   <= wr_start;
                tbl_end_q[wr_idx]     <= '0;
                tbl_level_q[wr_idx]   <= wr_level;
                tbl_parent_q[wr_idx]  <= wr_parent;
                tbl_matched_q[wr_idx] <= 1'b0;
            end
            if (wr_close) begin
                tbl_end_q[wr_idx]     <= wr_end;
                tbl_matched_q[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            capidx_q       <= '0;
            cap_len_q      <= '0;
            err_ov_q       <= 1'b0;
            err_un_q       <= 1'b0;
            notify_valid_q <= 1'b0;
            notify_idx_q   <= '0;
            root_matched_q <= 1'b0;
            root_end_q     <= '0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            pend_close_q   <= 1'b0;
            pend_name_q    <= '0;
            pend_pos_q     <= '0;
            rmw_level_q    <= '0;
            rmw_parent_q   <= '0;
        end else begin
            state_q        <= state_d;
            capidx_q       <= capidx_d;
            cap_len_q      <= cap_len_d;
            err_ov_q       <= err_ov_d;
            err_un_q       <= err_un_d;
            notify_valid_q <= notify_valid_d;
            notify_idx_q   <= notify_idx_d;
            root_matched_q <= root_matched_d;
            root_end_q     <= root_end_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            pend_close_q   <= pend_close_d;
            pend_name_q    <= pend_name_d;
            pend_pos_q     <= pend_pos_d;
            rmw_level_q    <= rmw_level_d;
            rmw_parent_q   <= rmw_parent_d;
        end
    end

`ifdef CAPTURE_TABLE_STATS_EN
    logic [IDX_W:0] stat_hwm_q, stat_hwm_d;
    logic [31:0]    stat_ops_q, stat_ops_d;

    always_comb begin
        stat_hwm_d = (cap_len_d > stat_hwm_q) ? cap_len_d : stat_hwm_q;
        stat_ops_d = stat_ops_q;
        if (accept && (stat_ops_q != 32'hFFFF_FFFF))
            stat_ops_d = stat_ops_q + 32'd1;
    end

    // Stats survive CLEAR; only rst zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hwm_q <= '0;
            stat_ops_q <= '0;
        end else begin
            stat_hwm_q <= stat_hwm_d;
            stat_ops_q <= stat_ops_d;
        end
    end

    assign stat_hwm = stat_hwm_q;
    assign stat_ops = stat_ops_q;
`endif

    assign op_ready      = (state_q == S_IDLE);
    assign capidx        = capidx_q;
    assign cap_len       = cap_len_q;
    assign notify_valid  = notify_valid_q;
    assign notify_idx    = notify_idx_q;
    assign root_matched  = root_matched_q;
    assign root_end      = root_end_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
endmodule

// File: tb/tb_capture_table.sv
// Directed bench for capture_table (DEPTH=4 so the full-table case is reachable).
module tb_capture_table;
    localparam int DEPTH = 4, POS_W = 16, NAME_W = 8, IDX_W = 2;
    localparam int RD_W = NAME_W + 2*POS_W + 8 + IDX_W + 1;
    localparam logic [1:0] OPEN = 2'd0, CLOSE = 2'd1, RESTORE = 2'd2, CLEAR = 2'd3;

    logic clk = 1'b0, rst = 1'b1;
    logic op_valid = 1'b0;
    logic [1:0] op_kind = '0;
    logic [NAME_W-1:0] op_name = '0;
    logic [POS_W-1:0] op_pos = '0;
    logic [IDX_W-1:0] op_capidx = '0;
    logic rd_en = 1'b0;
    logic [IDX_W-1:0] rd_idx = '0;
    logic op_ready, notify_valid, root_matched, err_overflow, err_underflow, rd_valid;
    logic [IDX_W-1:0] capidx, notify_idx;
    logic [IDX_W:0] cap_len;
    logic [POS_W-1:0] root_end;
    logic [RD_W-1:0] rd_data;
`ifdef CAPTURE_TABLE_STATS_EN
    logic [IDX_W:0] stat_hwm;
    logic [31:0] stat_ops;
`endif

    int vectors = 0, errors = 0;

    capture_table #(.DEPTH(DEPTH), .POS_W(POS_W), .NAME_W(NAME_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_name(op_name),
        .op_pos(op_pos), .op_capidx(op_capidx),
        .capidx(capidx), .cap_len(cap_len),
        .notify_valid(notify_valid), .notify_idx(notify_idx),
        .root_matched(root_matched), .root_end(root_end),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
`ifdef CAPTURE_TABLE_STATS_EN
        .stat_hwm(stat_hwm), .stat_ops(stat_ops),
`endif
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic m, input logic [1:0] par, input logic [7:0] lvl,
                                        input logic [15:0] e, input logic [15:0] s, input logic [7:0] nm);
        ent = 64'({m, par, lvl, e, s, nm});
    endfunction

    // Returns at a falling edge with op_ready high, or flags a timeout.
    task automatic wait_ready();
        int n = 0;
        while (op_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(op_ready), 64'd1);
    endtask

    // Presents one event for exactly one rising edge; returns at the next falling edge.
    task automatic op(input logic [1:0] k, input logic [7:0] nm, input logic [15:0] ps, input logic [1:0] ci);
        @(negedge clk);
        wait_ready();
        op_valid = 1'b1; op_kind = k; op_name = nm; op_pos = ps; op_capidx = ci;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] idx);
        @(negedge clk);
        rd_en = 1'b1; rd_idx = idx;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic r0, r1, r2, r3;
        int npulse;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_capidx", 64'(capidx), 0);
        chk("rst_cap_len", 64'(cap_len), 0);
        chk("rst_op_ready", 64'(op_ready), 1);
        chk("rst_notify", 64'(notify_valid), 0);
        chk("rst_root", {root_end, root_matched}, 0);
        chk("rst_err", {err_overflow, err_underflow}, 0);
        chk("rst_rd", {rd_data, rd_valid}, 0);
        rst = 1'b0;

        // Nested open/close
        op(OPEN, 3, 0, 0);
        chk("o1_len", 64'(cap_len), 1);
        chk("o1_idx", 64'(capidx), 0);
        op(OPEN, 5, 2, 0);
        chk("o2_busy", 64'(op_ready), 0);
        wait_ready();
        chk("o2_len", 64'(cap_len), 2);
        chk("o2_idx", 64'(capidx), 1);
        op(CLOSE, 0, 4, 0);
        wait_ready();
        chk("c1_notify", {notify_valid, notify_idx}, {1'b1, 2'd1});
        chk("c1_idx", 64'(capidx), 0);
        op(CLOSE, 0, 6, 0);
        wait_ready();
        chk("c2_notify", {notify_valid, notify_idx}, {1'b1, 2'd0});
        chk("c2_idx", 64'(capidx), 0);
        @(negedge clk);
        chk("c2_root", {root_end, root_matched}, {16'd6, 1'b1});
        rd(1);
        chk("ent1", 64'(rd_data), ent(1, 0, 1, 4, 2, 5));
        chk("ent1_vld", 64'(rd_valid), 1);
        rd(0);
        chk("ent0", 64'(rd_data), ent(1, 0, 0, 6, 0, 3));
        rd(2);
        chk("rd_oob", {rd_data, rd_valid}, 1);

        // Restore then reopen
        op(CLEAR, 0, 0, 0);
        chk("clr_len", 64'(cap_len), 0);
        chk("clr_root", 64'(root_matched), 0);
        op(OPEN, 1, 0, 0);
        op(OPEN, 2, 1, 0);
        wait_ready();
        op(RESTORE, 0, 0, 0);
        chk("rs_idx", 64'(capidx), 0);
        op(OPEN, 7, 9, 0);
        wait_ready();
        chk("rs_len", 64'(cap_len), 3);
        chk("rs_idx2", 64'(capidx), 2);
        rd(2);
        chk("ent2", 64'(rd_data), ent(0, 0, 1, 0, 9, 7));
        rd(1);
        chk("ent1_abandoned", 64'(rd_data), ent(0, 0, 1, 0, 1, 2));

        // Fill table, then overflow
        op(OPEN, 8, 10, 0);
        wait_ready();
        op(OPEN, 9, 11, 0);
        chk("ov_ready", 64'(op_ready), 1);
        chk("ov_flag", 64'(err_overflow), 1);
        chk("ov_len", 64'(cap_len), 4);
        chk("ov_idx", 64'(capidx), 3);
        rd(3);
        chk("ent3", 64'(rd_data), ent(0, 2, 2, 0, 10, 8));
        op(CLEAR, 0, 0, 0);
        chk("ov_clr", {err_overflow, cap_len}, 0);

        // Underflow
        op(CLOSE, 0, 3, 0);
        chk("un_close", 64'(err_underflow), 1);
        chk("un_close_st", {op_ready, capidx, cap_len}, {1'b1, 2'd0, 3'd0});
        op(CLEAR, 0, 0, 0);
        chk("un_clr", 64'(err_underflow), 0);
        op(OPEN, 1, 0, 0);
        op(OPEN, 2, 1, 0);
        wait_ready();
        op(RESTORE, 0, 0, 3);
        chk("un_rs", 64'(err_underflow), 1);
        chk("un_rs_st", {capidx, cap_len}, {2'd1, 3'd2});

        // OPEN then CLOSE with op_valid held
        op(CLEAR, 0, 0, 0);
        npulse = 0;
        @(negedge clk);
        r0 = op_ready; op_valid = 1'b1; op_kind = OPEN; op_name = 4; op_pos = 20;
        @(negedge clk);
        r1 = op_ready; op_kind = CLOSE; op_pos = 30;
        @(negedge clk);
        r2 = op_ready; npulse += int'(notify_valid);
        @(negedge clk);
        r3 = op_ready; npulse += int'(notify_valid); op_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            npulse += int'(notify_valid);
        end
        chk("hold_ready", {r0, r1, r2, r3}, 4'b1101);
        chk("hold_pulses", 64'(npulse), 1);
        chk("hold_root", {root_end, root_matched}, {16'd30, 1'b1});

        // Reset during CLOSE's EXEC
        op(CLEAR, 0, 0, 0);
        op(OPEN, 1, 0, 0);
        op(CLOSE, 0, 5, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rx_len", 64'(cap_len), 0);
        chk("rx_notify", 64'(notify_valid), 0);
        chk("rx_ready", 64'(op_ready), 1);
`ifdef CAPTURE_TABLE_STATS_EN
        chk("rx_hwm", 64'(stat_hwm), 0);
`endif
        rd(0);
        chk("rx_ent0", {rd_data, rd_valid}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
